// File: rtl/keypad_key_fifo.sv
// Keypad press-event consumer: decodes active-low {row,col} coordinates into
// 4-bit key codes and buffers them in a first-word-fall-through FIFO.
module keypad_key_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       key_coord,
  input  logic             rd_en,
  input  logic             clr_flags,
  output logic [3:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             key_valid,
  output logic [3:0]       last_key,
  output logic             overflow,
  output logic             bad_key
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  // Returns {valid, index}; index 0 is the nibble whose MSB is the low bit.
  function automatic logic [2:0] nib_dec(input logic [3:0] n);
    case (n)
      4'b0111: return 3'b100;
      4'b1011: return 3'b101;
      4'b1101: return 3'b110;
      4'b1110: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  logic [2:0] row_d, col_d;
  logic       evt, good_evt, bad_evt;

  assign row_d    = nib_dec(key_coord[7:4]);
  assign col_d    = nib_dec(key_coord[3:0]);
  assign evt      = |key_coord;
  assign good_evt = evt & row_d[2] & col_d[2];
  assign bad_evt  = evt & ~good_evt;

  // Stage 1: decode register; code_p1 only changes on a valid key, so it
  // doubles as last_key.
  logic       vld_p1;
  logic [3:0] code_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      code_p1 <= 4'h0;
      bad_key <= 1'b0;
    end else begin
      vld_p1 <= good_evt;
      if (good_evt) code_p1 <= key_code(row_d[1:0], col_d[1:0]);
      if (bad_evt)        bad_key <= 1'b1;
      else if (clr_flags) bad_key <= 1'b0;
    end
  end

  assign key_valid = vld_p1;
  assign last_key  = code_p1;

  // Stage 2: FIFO write/read; a pop on a full FIFO frees room for the push.
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             pop, push, drop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = rd_en & ~empty;
  assign push  = vld_p1 & (~full | pop);
  assign drop  = vld_p1 & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_p1;
  end

  assign rd_data = empty ? 4'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Scoreboard bench for keypad_key_fifo: accepted codes are queued at drive
// time and compared against rd_data as the FIFO is drained.
module tb_keypad_key_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_coord;
  logic       rd_en;
  logic       clr_flags;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       key_valid;
  logic [3:0] last_key;
  logic       overflow;
  logic       bad_key;

  int errs = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  keypad_key_fifo #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .rd_en(rd_en),
    .clr_flags(clr_flags), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .key_valid(key_valid), .last_key(last_key),
    .overflow(overflow), .bad_key(bad_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] k, input logic [3:0] code, input bit accept);
    key_coord = k;
    if (accept) exp_q.push_back(code);
    tick();
    key_coord = 8'h00;
  endtask

  // Compares the head against the scoreboard, then pops it.
  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) chk({tag, "_sb_underrun"}, 1, 0);
    else chk(tag, rd_data, exp_q.pop_front());
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  logic [7:0] sweep_k [6] = '{8'h77, 8'hBB, 8'hEB, 8'hE7, 8'hED, 8'hEE};
  logic [3:0] sweep_c [6] = '{4'h1, 4'h5, 4'h0, 4'hE, 4'hF, 4'hD};
  logic [7:0] ovf_k [9] = '{8'h77, 8'h7B, 8'h7D, 8'h7E, 8'hB7, 8'hBB, 8'hBD, 8'hBE, 8'hD7};
  logic [3:0] ovf_c [9] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB, 4'h7};
  logic [7:0] fill_k [8] = '{8'hDB, 8'hDD, 8'hDE, 8'hEB, 8'hED, 8'hEE, 8'h77, 8'hBB};
  logic [3:0] fill_c [8] = '{4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hD, 4'h1, 4'h5};

  initial begin
    int kv_cnt;
    int max_cnt;
    rst_n = 1'b0; key_coord = 8'h00; rd_en = 1'b0; clr_flags = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_last_key", last_key, 0);
    chk("rst_flags", {overflow, bad_key}, 0);

    // Decode sweep, back-to-back
    kv_cnt = 0; max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) send(sweep_k[i], sweep_c[i], 1'b1);
      else tick();
      kv_cnt += int'(key_valid);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("sweep_kv_pulses", kv_cnt, 6);
    chk("sweep_count_peak", max_cnt, 6);
    chk("sweep_last_key", last_key, 4'hD);
    for (int i = 0; i < 6; i++) pop_chk("sweep_pop");
    chk("sweep_empty", empty, 1);

    // Latency
    tick();
    send(8'hBB, 4'h5, 1'b1);
    chk("lat_kv_n1", key_valid, 1);
    chk("lat_last_n1", last_key, 5);
    chk("lat_empty_n1", empty, 1);
    tick();
    chk("lat_empty_n2", empty, 0);
    chk("lat_count_n2", count, 1);
    chk("lat_kv_n2", key_valid, 0);
    pop_chk("lat_pop");
    chk("lat_empty_after_pop", empty, 1);
    chk("lat_rd_data_empty", rd_data, 0);

    // Overflow: ninth key dropped
    for (int i = 0; i < 9; i++) send(ovf_k[i], ovf_c[i], i < 8);
    tick();
    tick();
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_last_key", last_key, 4'h7);
    for (int i = 0; i < 8; i++) pop_chk("ovf_drain");
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_sb_empty", exp_q.size(), 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Push arriving with a pop on a full FIFO
    for (int i = 0; i < 8; i++) send(fill_k[i], fill_c[i], 1'b1);
    tick();
    tick();
    chk("sim_full_before", full, 1);
    key_coord = 8'hE7;
    tick();
    key_coord = 8'h00;
    chk("sim_dec_valid", key_valid, 1);
    pop_chk("sim_pop");
    exp_q.push_back(4'hE);
    chk("sim_count", count, 8);
    chk("sim_overflow", overflow, 0);
    chk("sim_full_after", full, 1);
    for (int i = 0; i < 8; i++) pop_chk("sim_drain");
    chk("sim_empty", empty, 1);

    // Bad key, empty pop, flag clear, set-wins-over-clear
    send(8'h33, 4'h0, 1'b0);
    chk("bad_flag", bad_key, 1);
    chk("bad_no_kv", key_valid, 0);
    tick();
    chk("bad_count", count, 0);
    chk("bad_empty", empty, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_pop_count", count, 0);
    chk("empty_pop_empty", empty, 1);
    chk("empty_pop_rd_data", rd_data, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_flags", {overflow, bad_key}, 0);
    key_coord = 8'h70;
    clr_flags = 1'b1;
    tick();
    key_coord = 8'h00;
    clr_flags = 1'b0;
    chk("bad_set_wins", bad_key, 1);
    chk("bad_zero_nibble_no_kv", key_valid, 0);
    tick();
    chk("bad_zero_nibble_count", count, 0);

    // Reset mid-stream with a decode in flight
    send(8'h77, 4'h1, 1'b0);
    send(8'h7B, 4'h2, 1'b0);
    send(8'h7D, 4'h3, 1'b0);
    tick();
    tick();
    chk("rs_count_before", count, 3);
    key_coord = 8'hD7;
    tick();
    key_coord = 8'h00;
    chk("rs_in_flight", key_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_empty", empty, 1);
    chk("rs_count", count, 0);
    chk("rs_last_key", last_key, 0);
    chk("rs_flags", {overflow, bad_key}, 0);
    chk("rs_rd_data", rd_data, 0);
    tick();
    tick();
    chk("rs_no_late_push", count, 0);
    chk("rs_still_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
